// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the set-associative branch target buffer.
//   btb_entry_t      - valid/tag/target portion of one table entry (counter kept alongside)
//   btb_hash         - PC -> set index fold (low index bits XOR the next index bits)
//   btb_cnt_next     - saturating up/down counter step
//   btb_weak_taken   - counter value that just barely predicts taken
package btb_pkg;

    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    // Index fold: PC[idx_w+1:2] ^ PC[2*idx_w+1:idx_w+2], returned zero-extended.
    function automatic logic [31:0] btb_hash(input logic [31:0] pc, input int idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return ((pc >> 2) ^ (pc >> (idx_w + 2))) & mask;
    endfunction

    // Saturating counter step for a counter of 'bits' width.
    function automatic logic [31:0] btb_cnt_next(input logic [31:0] cnt, input logic taken,
                                                 input int bits);
        logic [31:0] max_val;
        logic [31:0] res;
        max_val = (32'd1 << bits) - 32'd1;
        if (taken) begin
            res = (cnt == max_val) ? cnt : cnt + 32'd1;
        end else begin
            res = (cnt == 32'd0) ? cnt : cnt - 32'd1;
        end
        return res;
    endfunction

    // Weak-taken value: only the counter MSB set.
    function automatic logic [31:0] btb_weak_taken(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/btb_plru.sv
// btb_plru: tree pseudo-LRU for one set.
//   bits      in   current tree bits of the set (WAYS-1 bits, 1 dummy bit when WAYS=1)
//   touch_way in   way being used this update
//   new_bits  out  tree bits after touching touch_way
//   victim    out  way the current tree bits point at for replacement
// Each tree bit points toward the side to evict next; touching a way points
// every bit on its path away from it.
module btb_plru #(
    parameter int WAYS = 2,
    parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int PW   = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PW-1:0] bits,
    input  logic [WW-1:0] touch_way,
    output logic [PW-1:0] new_bits,
    output logic [WW-1:0] victim
);

    if (WAYS == 4) begin : g_four
        // Root bit chooses the pair, bits[1]/bits[2] choose within left/right pair.
        always_comb begin
            new_bits    = bits;
            new_bits[0] = ~touch_way[1];
            if (touch_way[1]) begin
                new_bits[2] = ~touch_way[0];
            end else begin
                new_bits[1] = ~touch_way[0];
            end
            victim = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        end
    end else if (WAYS == 2) begin : g_two
        // Single bit names the way to evict.
        always_comb begin
            new_bits = ~touch_way;
            victim   = bits;
        end
    end else begin : g_one
        // Direct-mapped: nothing to track, always way 0.
        always_comb begin
            new_bits = '0;
            victim   = '0;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer.
//   clk, rst_n (sync, active-low), stall   - clock, reset, update hold
//   pc_f                                   - fetch PC, looked up combinationally
//   pc_x, is_branch_x, taken_x, target_x,
//   pred_taken_x, pred_target_x            - execute-stage resolution / update port
//   next_pc, pred_taken                    - fetch prediction (or recovery PC on flush)
//   flush                                  - execute-stage mispredict
//   stat_branches, stat_mispredicts        - wrapping retire statistics
module btb_assoc
    import btb_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [31:0]       pc_f,
    input  logic [31:0]       pc_x,
    input  logic              is_branch_x,
    input  logic              taken_x,
    input  logic [31:0]       target_x,
    input  logic              pred_taken_x,
    input  logic [31:0]       pred_target_x,
    output logic [31:0]       next_pc,
    output logic              pred_taken,
    output logic              flush,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX = $clog2(SETS);
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [CNT_BITS-1:0] WEAK_CNT = CNT_BITS'(btb_weak_taken(CNT_BITS));

    btb_entry_t          tbl_r  [SETS][WAYS];
    logic [CNT_BITS-1:0] cnt_r  [SETS][WAYS];
    logic [PW-1:0]       plru_r [SETS];
    logic [STAT_W-1:0]   stat_branches_r;
    logic [STAT_W-1:0]   stat_mispredicts_r;

    logic [IDX-1:0]  f_idx_s;
    logic [WAYS-1:0] f_match_s;
    logic            f_hit_s;
    logic [WW-1:0]   f_way_s;

    logic [IDX-1:0]  u_idx_s;
    logic [WAYS-1:0] u_match_s;
    logic [WAYS-1:0] u_invalid_s;
    logic            u_hit_s;
    logic [WW-1:0]   u_way_s;
    logic [WW-1:0]   u_inv_way_s;
    logic [WW-1:0]   plru_victim_s;
    logic [WW-1:0]   victim_way_s;
    logic [WW-1:0]   touch_way_s;
    logic [PW-1:0]   plru_new_s;

    logic            dir_wrong_s;
    logic            tgt_wrong_s;
    logic            do_update_s;

    assign f_idx_s = IDX'(btb_hash(pc_f, IDX));
    assign u_idx_s = IDX'(btb_hash(pc_x, IDX));

    // Fetch-side tag compare; a multi-way match resolves to the lowest way.
    always_comb begin
        f_match_s = '0;
        f_way_s   = '0;
        for (int w = 0; w < WAYS; w++) begin
            f_match_s[w] = tbl_r[f_idx_s][w].valid && (tbl_r[f_idx_s][w].tag == pc_f[31:2]);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            f_way_s = f_match_s[w] ? WW'(w) : f_way_s;
        end
        f_hit_s = |f_match_s;
    end

    // Update-side tag compare plus lowest-invalid-way search for allocation.
    always_comb begin
        u_match_s   = '0;
        u_invalid_s = '0;
        u_way_s     = '0;
        u_inv_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            u_match_s[w]   = tbl_r[u_idx_s][w].valid && (tbl_r[u_idx_s][w].tag == pc_x[31:2]);
            u_invalid_s[w] = ~tbl_r[u_idx_s][w].valid;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            u_way_s     = u_match_s[w]   ? WW'(w) : u_way_s;
            u_inv_way_s = u_invalid_s[w] ? WW'(w) : u_inv_way_s;
        end
        u_hit_s      = |u_match_s;
        victim_way_s = (|u_invalid_s) ? u_inv_way_s : plru_victim_s;
        touch_way_s  = u_hit_s ? u_way_s : victim_way_s;
    end

    btb_plru #(
        .WAYS (WAYS),
        .WW   (WW),
        .PW   (PW)
    ) u_plru (
        .bits      (plru_r[u_idx_s]),
        .touch_way (touch_way_s),
        .new_bits  (plru_new_s),
        .victim    (plru_victim_s)
    );

    assign dir_wrong_s = is_branch_x && (pred_taken_x != taken_x);
    assign tgt_wrong_s = is_branch_x && pred_taken_x && taken_x && (pred_target_x != target_x);
    assign flush       = dir_wrong_s || tgt_wrong_s;
    assign pred_taken  = f_hit_s && cnt_r[f_idx_s][f_way_s][CNT_BITS-1];
    assign do_update_s = !stall && is_branch_x;

    // Next-PC select: recovery PC on a mispredict wins over the fetch prediction.
    always_comb begin
        next_pc = pc_f + 32'd4;
        if (flush) begin
            next_pc = taken_x ? target_x : (pc_x + 32'd4);
        end else if (pred_taken) begin
            next_pc = tbl_r[f_idx_s][f_way_s].target;
        end else begin
            next_pc = pc_f + 32'd4;
        end
    end

    // Table, PLRU and statistics state; reset discards any update in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tbl_r[s][w] <= '0;
                    cnt_r[s][w] <= '0;
                end
            end
            stat_branches_r    <= '0;
            stat_mispredicts_r <= '0;
        end else if (do_update_s) begin
            stat_branches_r    <= stat_branches_r + STAT_W'(1);
            stat_mispredicts_r <= stat_mispredicts_r + STAT_W'(flush);
            if (u_hit_s) begin
                // A new taken target retrains from weak-taken rather than inheriting confidence.
                if (taken_x && (tbl_r[u_idx_s][u_way_s].target != target_x)) begin
                    tbl_r[u_idx_s][u_way_s].target <= target_x;
                    cnt_r[u_idx_s][u_way_s]        <= WEAK_CNT;
                end else begin
                    cnt_r[u_idx_s][u_way_s] <=
                        CNT_BITS'(btb_cnt_next(32'(cnt_r[u_idx_s][u_way_s]), taken_x, CNT_BITS));
                end
                plru_r[u_idx_s] <= plru_new_s;
            end else if (taken_x) begin
                tbl_r[u_idx_s][victim_way_s] <= '{valid: 1'b1, tag: pc_x[31:2], target: target_x};
                cnt_r[u_idx_s][victim_way_s] <= WEAK_CNT;
                plru_r[u_idx_s]              <= plru_new_s;
            end else begin
                plru_r[u_idx_s] <= plru_r[u_idx_s];
            end
        end else begin
            stat_branches_r <= stat_branches_r;
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (SETS=16, WAYS=2, CNT_BITS=2): directed
// scenarios followed by random traffic compared against a behavioural model
// that keeps per-way LRU timestamps (exact for two ways).
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc_f;
    logic [31:0] pc_x;
    logic        is_branch_x;
    logic        taken_x;
    logic [31:0] target_x;
    logic        pred_taken_x;
    logic [31:0] pred_target_x;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    btb_assoc #(
        .SETS     (16),
        .WAYS     (2),
        .CNT_BITS (2),
        .STAT_W   (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .pc_f             (pc_f),
        .pc_x             (pc_x),
        .is_branch_x      (is_branch_x),
        .taken_x          (taken_x),
        .target_x         (target_x),
        .pred_taken_x     (pred_taken_x),
        .pred_target_x    (pred_target_x),
        .next_pc          (next_pc),
        .pred_taken       (pred_taken),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_valid [16][2];
    logic [31:0] m_word  [16][2];
    logic [31:0] m_tgt   [16][2];
    int          m_cnt   [16][2];
    int          m_used  [16][2];
    int          m_tick;
    logic [31:0] m_branches;
    logic [31:0] m_mis;

    logic [31:0] pc_pool  [0:9];
    logic [31:0] tgt_pool [0:3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        return int'(((pc >> 2) & 32'hF) ^ ((pc >> 6) & 32'hF));
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s;
        s = m_index(pc);
        for (int w = 0; w < 2; w++) begin
            if (m_valid[s][w] && m_word[s][w] == (pc >> 2)) return w;
        end
        return -1;
    endfunction

    function automatic bit m_flush();
        return is_branch_x && ((pred_taken_x != taken_x) ||
               (pred_taken_x && taken_x && (pred_target_x != target_x)));
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_cnt[s][w]   = 0;
                m_used[s][w]  = 0;
            end
        end
        m_branches = 32'd0;
        m_mis      = 32'd0;
    endtask

    task automatic model_check();
        int s;
        int w;
        bit ep;
        bit ef;
        logic [31:0] enpc;
        s  = m_index(pc_f);
        w  = m_find(pc_f);
        ep = (w >= 0) ? (m_cnt[s][w] >= 2) : 1'b0;
        ef = m_flush();
        if (ef) enpc = taken_x ? target_x : pc_x + 32'd4;
        else if (ep) enpc = m_tgt[s][w];
        else enpc = pc_f + 32'd4;
        check_eq("pred_taken", 32'(pred_taken), 32'(ep));
        check_eq("flush", 32'(flush), 32'(ef));
        check_eq("next_pc", next_pc, enpc);
        check_eq("stat_branches", stat_branches, m_branches);
        check_eq("stat_mispredicts", stat_mispredicts, m_mis);
    endtask

    task automatic model_update();
        int s;
        int w;
        if (!rst_n) begin
            m_clear();
        end else if (!stall && is_branch_x) begin
            m_branches = m_branches + 32'd1;
            if (m_flush()) m_mis = m_mis + 32'd1;
            s = m_index(pc_x);
            w = m_find(pc_x);
            if (w >= 0) begin
                if (taken_x && m_tgt[s][w] != target_x) begin
                    m_tgt[s][w] = target_x;
                    m_cnt[s][w] = 2;
                end else if (taken_x) begin
                    m_cnt[s][w] = (m_cnt[s][w] == 3) ? 3 : m_cnt[s][w] + 1;
                end else begin
                    m_cnt[s][w] = (m_cnt[s][w] == 0) ? 0 : m_cnt[s][w] - 1;
                end
                m_tick++;
                m_used[s][w] = m_tick;
            end else if (taken_x) begin
                if (!m_valid[s][0]) w = 0;
                else if (!m_valid[s][1]) w = 1;
                else w = (m_used[s][0] < m_used[s][1]) ? 0 : 1;
                m_valid[s][w] = 1'b1;
                m_word[s][w]  = pc_x >> 2;
                m_tgt[s][w]   = target_x;
                m_cnt[s][w]   = 2;
                m_tick++;
                m_used[s][w] = m_tick;
            end
        end
    endtask

    // Drive one cycle's inputs at the negative edge and let combinational outputs settle.
    task automatic drive(input logic [31:0] pcf, input logic br, input logic [31:0] pcx,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic stl, input logic rst);
        pc_f          = pcf;
        is_branch_x   = br;
        pc_x          = pcx;
        taken_x       = tk;
        target_x      = tgt;
        pred_taken_x  = ptk;
        pred_target_x = ptgt;
        stall         = stl;
        rst_n         = rst;
        #1;
    endtask

    task automatic step();
        model_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pcf);
        drive(pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic branch(input logic [31:0] pcx, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        drive(32'h0, 1'b1, pcx, tk, tgt, ptk, ptgt, 1'b0, 1'b1);
    endtask

    initial begin
        pc_pool = '{32'h40, 32'h04, 32'h440, 32'h400, 32'h80,
                    32'h08, 32'h480, 32'h10, 32'h1040, 32'hFFFF_FFFC};
        tgt_pool = '{32'h100, 32'h200, 32'h300, 32'hFFFF_FFF0};
        m_tick = 0;

        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        m_clear();

        // Reset state.
        fetch(32'h40);
        check_eq("rst_pred_taken", 32'(pred_taken), 32'd0);
        check_eq("rst_next_pc", next_pc, 32'h44);
        check_eq("rst_flush", 32'(flush), 32'd0);
        check_eq("rst_stats", stat_branches | stat_mispredicts, 32'd0);
        step();

        // First taken branch mispredicts, then predicts taken.
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("alloc_flush", 32'(flush), 32'd1);
        check_eq("alloc_next_pc", next_pc, 32'h100);
        check_eq("same_cycle_old", 32'(pred_taken), 32'd0);
        step();
        fetch(32'h40);
        check_eq("hit_pred_taken", 32'(pred_taken), 32'd1);
        check_eq("hit_next_pc", next_pc, 32'h100);
        check_eq("mispred_stat", stat_mispredicts, 32'd1);
        step();

        // Counter saturation and decay.
        branch(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step();
        branch(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step();
        branch(32'h40, 1'b0, 32'h100, 1'b1, 32'h100); step();
        fetch(32'h40);
        check_eq("cnt2_pred", 32'(pred_taken), 32'd1);
        step();
        branch(32'h40, 1'b0, 32'h100, 1'b1, 32'h100); step();
        fetch(32'h40);
        check_eq("cnt1_next_pc", next_pc, 32'h44);
        step();
        drive(32'h80, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1);
        check_eq("nt_flush", 32'(flush), 32'd1);
        check_eq("nt_next_pc", next_pc, 32'h44);
        step();

        // Wrong target on a hit retrains to weak-taken.
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b1);
        check_eq("tgt_flush", 32'(flush), 32'd1);
        check_eq("tgt_next_pc", next_pc, 32'h200);
        step();
        fetch(32'h40);
        check_eq("tgt_new", next_pc, 32'h200);
        step();
        branch(32'h40, 1'b0, 32'h200, 1'b1, 32'h200); step();
        fetch(32'h40);
        check_eq("tgt_weak_cnt", 32'(pred_taken), 32'd0);
        step();

        // Replacement in set 1.
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); step();
        branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); step();
        branch(32'h04, 1'b1, 32'h300, 1'b0, 32'h0); step();
        branch(32'h04, 1'b1, 32'h300, 1'b1, 32'h300); step();
        branch(32'h440, 1'b1, 32'h200, 1'b0, 32'h0); step();
        fetch(32'h40);
        check_eq("evict_40", next_pc, 32'h44);
        step();
        fetch(32'h04);
        check_eq("keep_04", next_pc, 32'h300);
        step();
        fetch(32'h440);
        check_eq("keep_440", next_pc, 32'h200);
        check_eq("stat_br_4", stat_branches, 32'd4);
        check_eq("stat_mis_3", stat_mispredicts, 32'd3);
        step();

        // Stall holds state but not flush.
        drive(32'h04, 1'b1, 32'h04, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1);
        check_eq("stall_flush", 32'(flush), 32'd1);
        check_eq("stall_next_pc", next_pc, 32'h08);
        step();
        fetch(32'h04);
        check_eq("stall_stats", stat_branches, 32'd4);
        step();

        // Mid-run reset discards the pending update.
        drive(32'h04, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        fetch(32'h04);
        check_eq("rst2_miss", 32'(pred_taken), 32'd0);
        check_eq("rst2_stats", stat_branches, 32'd0);
        step();
        fetch(32'h80);
        check_eq("rst2_no_alloc", next_pc, 32'h84);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pcf;
            logic [31:0] pcx;
            logic [31:0] tgt;
            logic [31:0] ptgt;
            logic        ptk;
            int          s;
            int          w;
            pcf = pc_pool[$urandom_range(0, 9)];
            pcx = pc_pool[$urandom_range(0, 9)];
            tgt = tgt_pool[$urandom_range(0, 3)];
            s   = m_index(pcx);
            w   = m_find(pcx);
            if ($urandom_range(0, 1) == 0 && w >= 0) begin
                ptk  = (m_cnt[s][w] >= 2);
                ptgt = m_tgt[s][w];
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = tgt_pool[$urandom_range(0, 3)];
            end
            drive(pcf, ($urandom_range(0, 3) != 0), pcx, 1'($urandom_range(0, 1)), tgt, ptk,
                  ptgt, ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) != 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage, successor to the single-way hashed BTB. A combinational lookup in fetch predicts next PC; execute-stage branch outcomes update the table one cycle later, with misprediction detection and a recovery flush. Adds configurable sets, ways and counter width, tree pseudo-LRU replacement, explicit predicted-target compare, correct not-taken recovery and branch/mispredict statistics counters.

## Interface
- SETS, 16, number of sets (power of 2, ≥2); IDX = log2(SETS)
- WAYS, 2, associativity (1, 2 or 4)
- CNT_BITS, 2, saturating-counter width (≥1)
- STAT_W, 32, statistics counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  memory stall; blocks table and statistics updates
- pc_f  in  32  fetch-stage PC
- pc_x  in  32  execute-stage PC
- is_branch_x  in  1  execute-stage instruction is a conditional branch
- taken_x  in  1  resolved direction
- target_x  in  32  resolved taken target
- pred_taken_x  in  1  direction predicted when this branch was fetched
- pred_target_x  in  32  target predicted when fetched
- next_pc  out  32  predicted or recovery PC
- pred_taken  out  1  fetch prediction: taken
- flush  out  1  execute-stage mispredict; squash younger instructions
- stat_branches  out  STAT_W  branches retired
- stat_mispredicts  out  STAT_W  mispredicts retired

## Operation
- Index: idx = PC[IDX+1:2] ^ PC[2*IDX+1:IDX+2]. Tag = PC[31:2], full, so no aliasing.
- Entry: valid, tag[29:0], target[31:0], cnt[CNT_BITS-1:0]. Each set holds WAYS-1 PLRU bits.
- Lookup: hit = any way with valid and matching tag; a multi-way match (illegal) resolves to the lowest way. pred_taken = hit & cnt MSB.
- Mispredict: dir_wrong = is_branch_x & (pred_taken_x != taken_x); tgt_wrong = is_branch_x & pred_taken_x & taken_x & (pred_target_x != target_x); flush = dir_wrong | tgt_wrong.
- next_pc when flush: taken_x ? target_x : pc_x+4. Otherwise: pred_taken ? stored target : pc_f+4. Additions wrap at 32 bits.
- Update when !stall & is_branch_x, on the set indexed by pc_x:
  - Hit: cnt saturating inc if taken_x, dec otherwise. If taken_x and stored target ≠ target_x, write target_x and set cnt = 2^(CNT_BITS-1) (weak-taken). Touch PLRU.
  - Miss & taken_x: allocate. Victim is the lowest invalid way, otherwise the PLRU victim. Write valid=1, tag, target_x, cnt = weak-taken. Touch PLRU.
  - Miss & !taken_x: no change.
- Statistics: when !stall & is_branch_x, stat_branches += 1, and stat_mispredicts += flush. Both wrap.
- flush and next_pc do not depend on stall. While stall is held with a mispredict, flush stays asserted.

## Timing
- Lookup, flush and next_pc are zero-latency combinational. Table, PLRU and statistics change only on the clk edge.
- Update-to-lookup: a fetch in the same cycle as an update sees the old contents. The new contents are visible the next cycle. No bypass.
- PLRU touch happens only on the update port, not on fetch hits.
- Reset: all valid, cnt, PLRU and statistics bits clear to 0. Outputs after reset: pred_taken=0; next_pc=pc_f+4 (flush=0, given is_branch_x=0); stats 0. Reset asserted mid-stream discards the pending update that cycle.
- WAYS=1: no PLRU state; victim is always way 0.

## Structure
- Package btb_pkg: entry struct, hash function, saturating-counter update function, weak-taken constant.
- Sub-module btb_plru: per-set tree PLRU (touch way → new bits; bits → victim). Instantiated once on the update set index.

## Test plan
(SETS=16, WAYS=2, CNT_BITS=2.)
- Reset, then pc_f=0x40 → pred_taken=0, next_pc=0x44, flush=0, stats 0.
- pc_x=0x40 taken, target 0x100, pred_taken_x=0 → same cycle flush=1, next_pc=0x100. Next cycle pc_f=0x40 → pred_taken=1, next_pc=0x100; stat_mispredicts=1.
- Allocate 0x40, then 0x04, all in set 1. Update 0x04 again, then allocate 0x440 → 0x40 is evicted. Fetching 0x40 misses; fetching 0x04 and 0x440 hit.
- Counter for 0x40 at 2, taken ×2 → 3 (saturated). Not-taken → 2, still predicts taken. Not-taken → 1, pc_f=0x40 gives next_pc=0x44. Not-taken resolve with pred_taken_x=1 → flush, next_pc=0x44.
- Hit with pred_target_x=0x100, target_x=0x200, taken → flush, next_pc=0x200. Entry target becomes 0x200, cnt=2.
- stall=1 with a mispredicting branch → flush=1, but table and stats are unchanged after the edge. rst_n=0 mid-run → all entries miss next cycle and stats read 0.
